// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the KGP-RISC fetch stage: state encoding and
// default widths/step used by the fetch unit and its output buffer.
package fetch_unit_pkg;

  localparam int AWIDTH_DEF  = 32;
  localparam int DWIDTH_DEF  = 32;
  localparam int PC_STEP_DEF = 4;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry valid/ready output register of the fetch stage. Holds the
// instruction, its PC and the precomputed sequential PC.
import fetch_unit_pkg::*;

module fetch_buffer #(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              consume,
  input  logic [DWIDTH-1:0] load_instr,
  input  logic [AWIDTH-1:0] load_pc,
  output logic              valid,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] pc,
  output logic [AWIDTH-1:0] pc_next
);

  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(PC_STEP);

  // Flush beats a reload; a reload in the consume cycle keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      instr   <= '0;
      pc      <= '0;
      pc_next <= STEP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= load_instr;
      pc      <= load_pc;
      pc_next <= load_pc + STEP;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// KGP-RISC instruction fetch: PC register, single-outstanding memory
// request FSM, redirect/halt handling, feeding a one-entry output buffer.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter int                AWIDTH   = AWIDTH_DEF,
  parameter int                DWIDTH   = DWIDTH_DEF,
  parameter logic [AWIDTH-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [AWIDTH-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DWIDTH-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc,
  output logic [AWIDTH-1:0] instr_pc_next,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  input  logic              halt
);

  localparam logic [AWIDTH-1:0] STEP = AWIDTH'(PC_STEP);

  fetch_state_t      state, state_d;
  logic [AWIDTH-1:0] pc, pc_d;
  logic              load;

  // State and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_d;
      pc    <= pc_d;
    end
  end

  // Next state, PC update, buffer load and request generation.
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    load     = 1'b0;
    imem_req = (state == ST_FETCH) && !redirect && !halt
               && (!instr_valid || instr_ready);
    if (redirect) begin
      pc_d = redirect_pc;
    end else if ((state == ST_WAIT) && imem_rvalid) begin
      pc_d = pc + STEP;
      load = 1'b1;
    end else begin
      pc_d = pc;
    end
    case (state)
      ST_FETCH: begin
        if (redirect || halt) begin
          state_d = halt ? ST_HALTED : ST_FETCH;
        end else if (imem_req) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        // A redirect racing the response drops it; otherwise wait it out in DRAIN.
        if (redirect) begin
          state_d = imem_rvalid ? ST_FETCH : ST_DRAIN;
        end else if (imem_rvalid) begin
          state_d = halt ? ST_HALTED : ST_FETCH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (!redirect && imem_rvalid) begin
          state_d = halt ? ST_HALTED : ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        state_d = halt ? ST_HALTED : ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imem_addr = pc;

  fetch_buffer #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .PC_STEP(PC_STEP)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .flush     (redirect),
    .consume   (instr_valid && instr_ready),
    .load_instr(imem_rdata),
    .load_pc   (pc),
    .valid     (instr_valid),
    .instr     (instr),
    .pc        (instr_pc),
    .pc_next   (instr_pc_next)
  );

endmodule
